// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared widths, op codes, FSM encodings and op decode for the multi-cycle mul/div sequencer.
package mdu_seq_ctrl_pkg;

   localparam int XLEN = 64;
   localparam int OPW  = 5;
   localparam int CNTW = 7;

   localparam logic [CNTW-1:0] MDU_ITER_W  = 7'd64;
   localparam logic [CNTW-1:0] MDU_ITER_WW = 7'd32;

   localparam logic [2:0] MDU_IDLE = 3'd0;
   localparam logic [2:0] MDU_PREP = 3'd1;
   localparam logic [2:0] MDU_CALC = 3'd2;
   localparam logic [2:0] MDU_FIX  = 3'd3;
   localparam logic [2:0] MDU_DONE = 3'd4;

   localparam logic [OPW-1:0] ALU_MUL    = 5'd16;
   localparam logic [OPW-1:0] ALU_MULH   = 5'd17;
   localparam logic [OPW-1:0] ALU_MULHSU = 5'd18;
   localparam logic [OPW-1:0] ALU_MULHU  = 5'd19;
   localparam logic [OPW-1:0] ALU_DIV    = 5'd20;
   localparam logic [OPW-1:0] ALU_DIVU   = 5'd21;
   localparam logic [OPW-1:0] ALU_REM    = 5'd22;
   localparam logic [OPW-1:0] ALU_REMU   = 5'd23;
   localparam logic [OPW-1:0] ALU_MULW   = 5'd24;
   localparam logic [OPW-1:0] ALU_DIVW   = 5'd25;
   localparam logic [OPW-1:0] ALU_DIVUW  = 5'd26;
   localparam logic [OPW-1:0] ALU_REMW   = 5'd27;
   localparam logic [OPW-1:0] ALU_REMUW  = 5'd28;

   typedef struct packed {
      logic valid;
      logic is_mul;
      logic is_rem;
      logic word;
      logic sgn_a;
      logic sgn_b;
      logic high;
   } mdu_dec_t;

   function automatic mdu_dec_t mdu_decode(input logic [OPW-1:0] op);
      mdu_dec_t d;
      d       = '0;
      d.valid = 1'b1;
      case (op)
         ALU_MUL:    d.is_mul = 1'b1;
         ALU_MULH:   begin d.is_mul = 1'b1; d.high = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
         ALU_MULHSU: begin d.is_mul = 1'b1; d.high = 1'b1; d.sgn_a = 1'b1; end
         ALU_MULHU:  begin d.is_mul = 1'b1; d.high = 1'b1; end
         ALU_DIV:    begin d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
         ALU_DIVU:   ;
         ALU_REM:    begin d.is_rem = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
         ALU_REMU:   d.is_rem = 1'b1;
         ALU_MULW:   begin d.is_mul = 1'b1; d.word = 1'b1; end
         ALU_DIVW:   begin d.word = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
         ALU_DIVUW:  d.word = 1'b1;
         ALU_REMW:   begin d.word = 1'b1; d.is_rem = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
         ALU_REMUW:  begin d.word = 1'b1; d.is_rem = 1'b1; end
         default:    d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iteration datapath: one 65-bit adder/subtractor shared by shift-add multiply and
// restoring divide, advancing the {acc, low} pair by one bit per step.
module mdu_iter_core
   import mdu_seq_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            mul_i,
   input  logic [XLEN-1:0] opnd_i,
   input  logic [XLEN-1:0] low_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] low_o
);
   logic [XLEN-1:0] acc_q, acc_d, low_q, low_d, opnd_q;
   logic            mul_q;
   logic [XLEN:0]   add_a, add_b;
   logic            cin, no_borrow;
   logic [XLEN+1:0] sum;

   // Divide feeds {rem, next dividend bit} minus divisor through the same adder via ~b + 1.
   always_comb begin
      if (mul_q) begin
         add_a = {1'b0, acc_q};
         add_b = low_q[0] ? {1'b0, opnd_q} : '0;
         cin   = 1'b0;
      end else begin
         add_a = {acc_q, low_q[XLEN-1]};
         add_b = ~{1'b0, opnd_q};
         cin   = 1'b1;
      end
   end

   assign sum       = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, cin};
   assign no_borrow = sum[XLEN+1];

   always_comb begin
      if (mul_q) begin
         acc_d = sum[XLEN:1];
         low_d = {sum[0], low_q[XLEN-1:1]};
      end else begin
         acc_d = no_borrow ? sum[XLEN-1:0] : add_a[XLEN-1:0];
         low_d = {low_q[XLEN-2:0], no_borrow};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         low_q  <= '0;
         opnd_q <= '0;
         mul_q  <= 1'b0;
      end else if (load_i) begin
         acc_q  <= '0;
         low_q  <= low_i;
         opnd_q <= opnd_i;
         mul_q  <= mul_i;
      end else if (step_i) begin
         acc_q  <= acc_d;
         low_q  <= low_d;
      end
   end

   assign acc_o = acc_q;
   assign low_o = low_q;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle RV64M sequencer: handshakes, FSM, iteration counter, operand prep and
// sign/width fix-up around the shared iteration core.
module mdu_seq_ctrl
   import mdu_seq_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  alu_op,
   input  logic [XLEN-1:0] operand_1,
   input  logic [XLEN-1:0] operand_2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   logic [2:0]        state_q, state_d;
   logic [OPW-1:0]    op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;
   mdu_dec_t          dec, in_dec;
   logic [XLEN-1:0]   a_w, b_w, mag_a, mag_b, min_w, special_res, fix_res;
   logic [XLEN-1:0]   div_sel, div_val, core_acc, core_low, core_opnd, core_low_init;
   logic              neg_a, neg_b, is_div, div_zero, div_ovf, div_neg, core_load, core_step;
   logic [2*XLEN-1:0] prod, prod_f;

   always_comb begin
      dec    = mdu_decode(op_q);
      in_dec = mdu_decode(alu_op);
      if (dec.word) begin
         a_w   = dec.sgn_a ? sext32(a_q[31:0]) : {32'b0, a_q[31:0]};
         b_w   = dec.sgn_b ? sext32(b_q[31:0]) : {32'b0, b_q[31:0]};
         min_w = sext32(32'h8000_0000);
      end else begin
         a_w   = a_q;
         b_w   = b_q;
         min_w = {1'b1, {(XLEN-1){1'b0}}};
      end
      neg_a    = dec.sgn_a & a_w[XLEN-1];
      neg_b    = dec.sgn_b & b_w[XLEN-1];
      mag_a    = neg_a ? -a_w : a_w;
      mag_b    = neg_b ? -b_w : b_w;
      is_div   = dec.valid & ~dec.is_mul;
      div_zero = is_div & (b_w == '0);
      div_ovf  = is_div & dec.sgn_a & (a_w == min_w) & (b_w == '1);
      if (div_zero) special_res = dec.is_rem ? a_w : '1;
      else          special_res = dec.is_rem ? '0 : a_w;
      if (dec.word) special_res = sext32(special_res[31:0]);

      // Word divides park the 32-bit dividend in the top half so 32 shifts consume it.
      core_opnd     = dec.is_mul ? mag_a : mag_b;
      core_low_init = dec.is_mul ? mag_b : (dec.word ? {mag_a[31:0], 32'b0} : mag_a);

      prod    = {core_acc, core_low};
      prod_f  = quot_neg_q ? -prod : prod;
      div_sel = dec.is_rem ? core_acc : (dec.word ? {32'b0, core_low[31:0]} : core_low);
      div_neg = dec.is_rem ? rem_neg_q : quot_neg_q;
      div_val = div_neg ? -div_sel : div_sel;
      if (dec.is_mul)
         fix_res = dec.high ? prod_f[2*XLEN-1:XLEN]
                            : (dec.word ? sext32(core_low[XLEN-1:32]) : prod_f[XLEN-1:0]);
      else
         fix_res = dec.word ? sext32(div_val[31:0]) : div_val;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      if (flush) begin
         state_d = MDU_IDLE;
      end else begin
         case (state_q)
            MDU_IDLE: if (in_valid && in_dec.valid) begin
               state_d = MDU_PREP;
               op_d    = alu_op;
               a_d     = operand_1;
               b_d     = operand_2;
            end
            MDU_PREP: if (div_zero || div_ovf) begin
               result_d = special_res;
               state_d  = MDU_DONE;
            end else begin
               core_load  = 1'b1;
               cnt_d      = dec.word ? MDU_ITER_WW : MDU_ITER_W;
               quot_neg_d = neg_a ^ neg_b;
               rem_neg_d  = neg_a;
               state_d    = MDU_CALC;
            end
            MDU_CALC: begin
               core_step = 1'b1;
               cnt_d     = cnt_q - 1'b1;
               if (cnt_q == 7'd1) state_d = MDU_FIX;
            end
            MDU_FIX: begin
               result_d = fix_res;
               state_d  = MDU_DONE;
            end
            MDU_DONE: if (out_ready) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MDU_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
      end
   end

   mdu_iter_core u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (core_load),
      .step_i (core_step),
      .mul_i  (dec.is_mul),
      .opnd_i (core_opnd),
      .low_i  (core_low_init),
      .acc_o  (core_acc),
      .low_o  (core_low)
   );

   assign in_ready  = (state_q == MDU_IDLE);
   assign out_valid = (state_q == MDU_DONE);
   assign busy      = (state_q != MDU_IDLE);
   assign result    = result_q;

endmodule
